// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: req/gnt/rvalid data-memory access, load/store lane handling,
// bus timeout, MEM/WB register. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    input  logic [2:0]  ex_funct3,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    state_t        state, state_next;
    logic [CW-1:0] cnt;

    logic          op_we, op_reg_write, op_mem_to_reg;
    logic [31:0]   op_addr, op_wdata;
    logic [3:0]    op_be;
    logic [4:0]    op_rd;
    logic [2:0]    op_funct3;

    logic          memop, misalign, accept, progress, done, timeout, finish;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;

`ifdef MEM_MISALIGN_TRAP_EN
    logic half_acc, word_acc;
    // Loads and stores decode size differently: funct3 100/101 are byte/half loads but word stores.
    always_comb begin
        half_acc = ex_mem_read ? (ex_funct3[1:0] == 2'b01) : (ex_funct3 == 3'b001);
        word_acc = ex_mem_read ? ex_funct3[1] : (ex_funct3[2:1] != 2'b00);
        misalign = ex_valid && memop &&
                   ((half_acc && ex_alu_result[0]) || (word_acc && (ex_alu_result[1:0] != 2'b00)));
    end
`else
    assign misalign = 1'b0;
`endif

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*off +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_rs2_data;
        case (ex_funct3)
            3'b000: begin
                st_be    = 4'b0001 << ex_alu_result[1:0];
                st_wdata = {4{ex_rs2_data[7:0]}};
            end
            3'b001: begin
                st_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state || state == IDLE) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (timeout || done) state_next = IDLE;
                     else if (dmem_gnt) state_next = WAIT;
            WAIT:    if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Abort counts as completion so upstream still advances exactly once per access.
    always_comb begin
        memop     = ex_mem_read || ex_mem_write;
        accept    = (state == IDLE) && ex_valid && memop && !misalign;
        progress  = (state == REQ) ? dmem_gnt : ((state == WAIT) && dmem_rvalid);
        done      = ((state == REQ) && dmem_gnt && (op_we || dmem_rvalid)) ||
                    ((state == WAIT) && dmem_rvalid);
        timeout   = (state != IDLE) && !progress && (cnt == CW'(TIMEOUT_CYCLES - 1));
        finish    = done || timeout;
        mem_stall = accept || ((state != IDLE) && !finish);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req      <= 1'b0;
            op_we         <= 1'b0;
            op_addr       <= '0;
            op_wdata      <= '0;
            op_be         <= '0;
            op_rd         <= '0;
            op_reg_write  <= 1'b0;
            op_mem_to_reg <= 1'b0;
            op_funct3     <= '0;
        end else begin
            dmem_req <= (state_next == REQ);
            if (accept) begin
                op_we         <= ex_mem_write;
                op_addr       <= ex_alu_result;
                op_wdata      <= st_wdata;
                op_be         <= ex_mem_write ? st_be : 4'b0000;
                op_rd         <= ex_rd;
                op_reg_write  <= ex_reg_write;
                op_mem_to_reg <= ex_mem_to_reg;
                op_funct3     <= ex_funct3;
            end
        end
    end

    assign dmem_we    = op_we;
    assign dmem_addr  = {op_addr[31:2], 2'b00};
    assign dmem_wdata = op_wdata;
    assign dmem_be    = op_be;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_alu_result <= '0;
            wb_data       <= '0;
            bus_err       <= 1'b0;
            misalign_exc  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            bus_err      <= 1'b0;
            misalign_exc <= 1'b0;
            if (state == IDLE) begin
                if (ex_valid && (!memop || misalign)) begin
                    wb_valid      <= 1'b1;
                    wb_rd         <= ex_rd;
                    wb_reg_write  <= ex_reg_write && !misalign;
                    wb_mem_to_reg <= ex_mem_to_reg;
                    wb_alu_result <= ex_alu_result;
                    misalign_exc  <= misalign;
                end
            end else if (finish) begin
                wb_valid      <= 1'b1;
                wb_rd         <= op_rd;
                wb_reg_write  <= op_reg_write && !timeout;
                wb_mem_to_reg <= op_mem_to_reg;
                wb_alu_result <= op_addr;
                wb_data       <= (timeout || op_we) ? '0 : load_ext(op_funct3, op_addr[1:0], dmem_rdata);
                bus_err       <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;
    localparam int unsigned T = 64;

    logic        clk, reset;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] ex_alu_result, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, bus_err, misalign_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result, wb_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_funct3(ex_funct3),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_result(wb_alu_result), .wb_data(wb_data),
        .bus_err(bus_err), .misalign_exc(misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> ((a % 4) * 8)) & 32'hFF;
        h = (rdata >> (((a / 2) % 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit model_mis(input bit st, input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        int unsigned size;
        if (st) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        return (a % size) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Non-memory instruction or bubble; gnt/rvalid noise must be ignored in IDLE.
    task automatic run_alu(input bit v, input logic [4:0] rd, input logic [31:0] res,
                           input bit rw, input bit m2r);
        ex_valid = v; ex_mem_read = 0; ex_mem_write = 0; ex_rd = rd; ex_alu_result = res;
        ex_reg_write = rw; ex_mem_to_reg = m2r; ex_funct3 = 3'($urandom);
        ex_rs2_data = $urandom; dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom);
        dmem_rdata = $urandom;
        #1 check("alu_stall", mem_stall, 0);
        next_cycle();
        dmem_gnt = 0; dmem_rvalid = 0;
        check("alu_wb_valid", wb_valid, v);
        check("alu_req", dmem_req, 0);
        if (v) begin
            check("alu_rd", wb_rd, rd);
            check("alu_result", wb_alu_result, res);
            check("alu_rw", wb_reg_write, rw);
            check("alu_m2r", wb_mem_to_reg, m2r);
            check("alu_data", wb_data, 0);
            check("alu_buserr", bus_err, 0);
        end
    endtask

    // G: REQ cycles before gnt (gnt in REQ cycle G). R: cycles after gnt until rvalid.
    task automatic run_mem(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input logic [4:0] rd, input bit rw,
                           input bit m2r, input int unsigned g, input int unsigned r,
                           input logic [31:0] rdata);
        bit mis, fin, tmo, wait_ph, nxt_wait;
        int unsigned k;
        mis = model_mis(st, f3, a);
        ex_valid = 1; ex_mem_read = !st; ex_mem_write = st; ex_funct3 = f3; ex_alu_result = a;
        ex_rs2_data = rs2; ex_rd = rd; ex_reg_write = rw; ex_mem_to_reg = m2r;
        dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
        #1 check("mem_stall_idle", mem_stall, !mis);
        next_cycle();
        if (mis) begin
            check("mis_valid", wb_valid, 1);
            check("mis_exc", misalign_exc, 1);
            check("mis_rw", wb_reg_write, 0);
            check("mis_req", dmem_req, 0);
            return;
        end
        check("mem_accept_wbv", wb_valid, 0);
        fin = 0; tmo = 0; wait_ph = 0; k = 0;
        while (!fin) begin
            nxt_wait = wait_ph;
            dmem_rdata = $urandom;
            if (!wait_ph) begin
                check("req_high", dmem_req, 1);
                check("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
                check("req_we", dmem_we, st);
                check("req_be", dmem_be, st ? model_be(f3, a) : 4'h0);
                if (st) check("req_wdata", dmem_wdata, model_wdata(f3, rs2));
                dmem_gnt = (k == g);
                dmem_rvalid = !st && (k == g) && (r == 0);
                if (dmem_rvalid) dmem_rdata = rdata;
                if (k == g) begin
                    if (st || r == 0) fin = 1;
                    else nxt_wait = 1;
                end else if (k == T - 1) begin
                    fin = 1; tmo = 1;
                end
            end else begin
                check("wait_req_low", dmem_req, 0);
                dmem_gnt = 0;
                dmem_rvalid = (k == r - 1);
                if (dmem_rvalid) begin
                    dmem_rdata = rdata; fin = 1;
                end else if (k == T - 1) begin
                    fin = 1; tmo = 1;
                end
            end
            #1 check("mem_stall", mem_stall, !fin);
            next_cycle();
            dmem_gnt = 0; dmem_rvalid = 0;
            k = (nxt_wait != wait_ph) ? 0 : k + 1;
            wait_ph = nxt_wait;
            if (!fin) check("mem_wbv_busy", wb_valid, 0);
        end
        check("done_valid", wb_valid, 1);
        check("done_rd", wb_rd, rd);
        check("done_alu", wb_alu_result, a);
        check("done_m2r", wb_mem_to_reg, m2r);
        check("done_rw", wb_reg_write, tmo ? 0 : rw);
        check("done_data", wb_data, (tmo || st) ? 0 : model_load(f3, a, rdata));
        check("done_buserr", bus_err, tmo);
        check("done_req", dmem_req, 0);
        check("done_misexc", misalign_exc, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
        ex_mem_to_reg = 0; ex_rd = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_funct3 = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        next_cycle(); next_cycle();
        check("rst_req", dmem_req, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_rd", wb_rd, 0);
        check("rst_alu", wb_alu_result, 0);
        check("rst_data", wb_data, 0);
        check("rst_buserr", bus_err, 0);
        check("rst_misexc", misalign_exc, 0);
        reset = 0;
        next_cycle();

        run_alu(1, 5'd5, 32'h1234, 1, 0);
        run_mem(0, 3'b000, 32'h103, $urandom, 5'd7, 1, 1, 0, 0, 32'h80FF_FF00);
        check("lb_const", wb_data, 32'hFFFF_FF80);
        run_mem(1, 3'b001, 32'h102, 32'hABCD_1234, 5'd0, 0, 0, 2, 0, 32'h0);
        run_mem(0, 3'b101, 32'h200, 0, 5'd9, 1, 1, 0, 2, 32'h0000_8001);
        check("lhu_const", wb_data, 32'h0000_8001);
        run_alu(0, 5'd3, 32'h55, 1, 0);
        run_mem(0, 3'b010, 32'h400, 0, 5'd4, 1, 1, T + 5, 0, 32'h1);
        run_alu(1, 5'd6, 32'hCAFE, 1, 0);
        run_mem(0, 3'b010, 32'h404, 0, 5'd4, 1, 1, 1, T + 5, 32'h1);
        run_mem(0, 3'b010, 32'h408, 0, 5'd4, 1, 1, T - 1, T, 32'h1234_5678);
`ifdef MEM_MISALIGN_TRAP_EN
        run_mem(0, 3'b010, 32'h102, 0, 5'd8, 1, 1, 0, 0, 32'h0);
`endif

        // Reset while waiting for rvalid; a late rvalid must not produce a writeback.
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h300; ex_rd = 5'd11; ex_reg_write = 1; ex_mem_to_reg = 1;
        next_cycle();
        dmem_gnt = 1;
        next_cycle();
        dmem_gnt = 0; ex_valid = 0; reset = 1;
        #1;
        check("rstw_req", dmem_req, 0);
        check("rstw_wbv", wb_valid, 0);
        check("rstw_stall", mem_stall, 0);
        check("rstw_data", wb_data, 0);
        next_cycle();
        reset = 0; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        #1 check("rstw_stall2", mem_stall, 0);
        next_cycle();
        dmem_rvalid = 0;
        check("rstw_ignored", wb_valid, 0);
        check("rstw_req2", dmem_req, 0);
        run_alu(1, 5'd12, 32'h77, 1, 0);

        for (int i = 0; i < 200; i++) begin
            int unsigned kind, g, r;
            kind = $urandom_range(0, 9);
            g = ($urandom_range(0, 19) == 0) ? T + 3 : $urandom_range(0, 3);
            r = ($urandom_range(0, 19) == 0) ? T + 3 : $urandom_range(0, 3);
            if (kind < 3)
                run_alu(kind != 0, 5'($urandom), $urandom, 1'($urandom), 1'($urandom));
            else
                run_mem(kind >= 7, 3'($urandom), $urandom, $urandom, 5'($urandom),
                        1'($urandom), 1'($urandom), g, r, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
